// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit: PC, synchronous imem request, field split and valid/ready hand-off.
// Optional FETCH_PERF_EN adds saturating handshake and stall counters.
module instr_fetch #(
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        upcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        func,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       perf_issued,
    output logic [15:0]       perf_stall
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RESP = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
    logic              handshake;

    assign handshake = out_valid & out_ready;

    // Redirect pre-empts any request; rst gates the strobe while the async reset is held.
    always_comb begin
        state_nxt = state;
        imem_en   = 1'b0;
        imem_addr = pc;
        if (redirect) begin
            state_nxt = S_REQ;
        end else begin
            case (state)
                S_REQ: begin
                    imem_en   = 1'b1;
                    state_nxt = S_RESP;
                end
                S_RESP: state_nxt = S_HOLD;
                S_HOLD: begin
                    if (handshake) begin
                        imem_en   = 1'b1;
                        state_nxt = S_RESP;
                    end
                end
                default: state_nxt = S_REQ;
            endcase
        end
        if (rst) imem_en = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            instr     <= '0;
            instr_pc  <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                pc        <= redirect_pc;
                out_valid <= 1'b0;
            end else if (state == S_RESP) begin
                instr     <= imem_rdata;
                instr_pc  <= pc;
                pc        <= pc + 1'b1;
                out_valid <= 1'b1;
            end else if (state == S_HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign upcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign func   = instr[5:0];
    assign imm    = instr[15:0];

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (handshake && perf_issued != '1)
                perf_issued <= perf_issued + 16'd1;
            if (out_valid && !out_ready && perf_stall != '1)
                perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule
